// File: rtl/apb_master_if.sv
// APB initiator bundle: valid/ready command port, valid/ready response port, APB master bus.
// Latency: none; this is a plain signal bundle.
// Backpressure: cmd_ready / rsp_ready / PREADY carry backpressure on their respective channels.
//
// Modports:
//   master : view of apb_master (drives cmd_ready, rsp_*, busy and the APB control/address/data)
//   slave  : view of the surroundings (command source, response sink, APB completer)
interface apb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // status
    logic                  busy;

    // APB
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator: turns one valid/ready command into one APB SETUP+ACCESS transfer and returns a response.
// Latency: accept at edge N -> SETUP N+1, ACCESS N+2, rsp_valid N+3 plus one cycle per PREADY-low cycle.
// Backpressure: one transfer outstanding; cmd_ready only in IDLE, response held until rsp_ready.
//
// Ports:
//   PCLK    : clock, everything on the rising edge
//   PRESET  : synchronous active-high reset; abandons any in-flight transfer without a response
//   bus     : apb_master_if.master -- cmd_* request, rsp_* response, busy, APB master signals
//
// Build option APB_MST_TIMEOUT_EN: when defined, an ACCESS phase that sees PREADY low for
// TIMEOUT_CYCLES consecutive cycles is aborted and answered with rsp_err=1, rsp_timeout=1.
// When undefined, ACCESS waits forever and rsp_timeout is constant 0. Ports are identical.
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);

    // A zero limit would abort before the completer ever gets a cycle to answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Request as it is presented on APB; held from SETUP until the next accepted command.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    // Response captured at ACCESS completion and held through RESP.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    state_t state;
    req_t   req_q;
    rsp_t   rsp_q;
    logic   cmd_ready_q;
    logic   rsp_valid_q;
    logic   busy_q;
    logic   psel_q;
    logic   penable_q;

`ifdef APB_MST_TIMEOUT_EN
    // Counts PREADY-low ACCESS cycles already seen; abort fires on the low cycle that
    // would make the count reach TIMEOUT_CYCLES.
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             rsp_timeout_q;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            req_q       <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
            tmo_cnt       <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // cmd_ready is registered high in IDLE, so cmd_valid alone is the handshake.
                    if (bus.cmd_valid) begin
                        req_q.write <= bus.cmd_write;
                        req_q.addr  <= bus.cmd_addr;
                        req_q.wdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        psel_q      <= 1'b1;
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_MST_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end

                ACCESS: begin
                    // PRDATA/PSLVERR are only meaningful in the PREADY cycle; a ready
                    // on the limit cycle still wins over the timeout.
                    if (bus.PREADY) begin
                        rsp_q.rdata <= req_q.write ? '0 : bus.PRDATA;
                        rsp_q.err   <= bus.PSLVERR;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
`ifdef APB_MST_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                RESP: begin
                    // cmd_ready comes back one cycle after the consume edge, so a response
                    // and a new command never handshake in the same cycle.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.busy      = busy_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = req_q.write;
    assign bus.PADDR     = req_q.addr;
    assign bus.PWDATA    = req_q.wdata;

`ifdef APB_MST_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed commands, a programmable APB completer, and a transfer-level
// model that predicts every output each cycle from the accepted command and the completer setup.
`timescale 1ns/1ps
module tb_apb_master;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int TMO   = 16;
    localparam int NEVER = 1000000;
`ifdef APB_MST_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK  (clk),
        .PRESET(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completer setup for the next transfer.
    int         cfg_wait  = 0;     // PREADY-low cycles before completion
    logic [7:0] cfg_rdata = 8'h00;
    logic       cfg_err   = 1'b0;
    bit         cfg_stuck = 1'b0;  // PREADY never rises

    // APB completer: junk on PRDATA/PSLVERR except in the completing cycle.
    int acc = 0;
    always @(negedge clk) begin
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
            if (!cfg_stuck && acc == cfg_wait) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = cfg_rdata;
                bus.PSLVERR = cfg_err;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = 8'hEE;
                bus.PSLVERR = 1'b1;
            end
            acc++;
        end else begin
            acc         = 0;
            bus.PREADY  = 1'b0;
            bus.PRDATA  = 8'hEE;
            bus.PSLVERR = 1'b1;
        end
    end

    // Transfer-level model. t = index of the current cycle counted from the accept edge
    // (t=1 SETUP); ACCESS spans t=2..2+w, response visible from t=3+w until consumed.
    bit         live = 1'b0, outst = 1'b0, has_last = 1'b0;
    int         t = 0, w = 0, cyc = 0, acc_count = 0;
    logic       m_write = 1'b0;
    logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic       m_err = 1'b0, m_to = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            live     = 1'b1;
            outst    = 1'b0;
            has_last = 1'b0;
        end else if (!outst) begin
            if (bus.cmd_valid === 1'b1) begin
                outst    = 1'b1;
                has_last = 1'b1;
                t        = 1;
                acc_count++;
                m_write  = bus.cmd_write;
                m_addr   = bus.cmd_addr;
                m_wdata  = bus.cmd_write ? bus.cmd_wdata : 8'h00;
                if (cfg_stuck) begin
                    w       = TMO_EN ? TMO - 1 : NEVER;
                    m_rdata = 8'h00;
                    m_err   = 1'b1;
                    m_to    = 1'b1;
                end else begin
                    w       = cfg_wait;
                    m_rdata = bus.cmd_write ? 8'h00 : cfg_rdata;
                    m_err   = cfg_err;
                    m_to    = 1'b0;
                end
            end
        end else if (t >= 3 + w && bus.rsp_ready === 1'b1) begin
            outst = 1'b0;
        end else begin
            t++;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            bit e_sel, e_en, e_rv;
            e_sel = outst && t >= 1 && t <= 2 + w;
            e_en  = outst && t >= 2 && t <= 2 + w;
            e_rv  = outst && t >= 3 + w;
            chk("cmd_ready", bus.cmd_ready, !outst);
            chk("busy", bus.busy, outst);
            chk("PSEL", bus.PSEL, e_sel);
            chk("PENABLE", bus.PENABLE, e_en);
            chk("rsp_valid", bus.rsp_valid, e_rv);
            chk("PADDR", bus.PADDR, has_last ? m_addr : 8'h00);
            chk("PWRITE", bus.PWRITE, has_last ? m_write : 1'b0);
            chk("PWDATA", bus.PWDATA, has_last ? m_wdata : 8'h00);
            if (e_rv) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk("rsp_err", bus.rsp_err, m_err);
                chk("rsp_timeout", bus.rsp_timeout, m_to);
            end
        end
    end

    // Present one command (called at a negedge); returns at the negedge of the SETUP cycle.
    task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input int wt, input logic [7:0] rd, input bit er, input bit stk);
        int start;
        cfg_wait  = wt;
        cfg_rdata = rd;
        cfg_err   = er;
        cfg_stuck = stk;
        start = acc_count;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int i = 0; i < 50 && acc_count == start; i++) @(negedge clk);
        chk("accept", acc_count != start, 1);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 8'hFF;
    endtask

    // Count ACCESS cycles until rsp_valid, capturing the response fields.
    task automatic run_to_resp(input int limit, output int n, output bit got,
                               output logic [7:0] rd, output logic er, output logic to);
        n = 0; got = 1'b0; rd = 'x; er = 'x; to = 'x;
        for (int i = 0; i < limit; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1;
                rd  = bus.rsp_rdata;
                er  = bus.rsp_err;
                to  = bus.rsp_timeout;
                break;
            end
            if (bus.PENABLE === 1'b1) n++;
            @(negedge clk);
        end
        chk("response arrived", got, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && outst; i++) @(negedge clk);
        chk("back to idle", outst, 0);
    endtask

    int         n;
    bit         got;
    logic [7:0] rd;
    logic       er, to;
    int         tacc [4];
    int         start;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset cmd_ready", bus.cmd_ready, 1);
        chk("reset PSEL", bus.PSEL, 0);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset PADDR", bus.PADDR, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x04 <- 0xA5, zero wait states.
        issue(1'b1, 8'h04, 8'hA5, 0, 8'h00, 1'b0, 1'b0);
        chk("t1 PSEL N+1", bus.PSEL, 1);
        chk("t1 PENABLE N+1", bus.PENABLE, 0);
        chk("t1 PADDR", bus.PADDR, 8'h04);
        chk("t1 PWDATA", bus.PWDATA, 8'hA5);
        @(negedge clk);
        chk("t1 PENABLE N+2", bus.PENABLE, 1);
        @(negedge clk);
        chk("t1 rsp_valid N+3", bus.rsp_valid, 1);
        chk("t1 rsp_rdata", bus.rsp_rdata, 8'h00);
        chk("t1 rsp_err", bus.rsp_err, 0);
        chk("t1 PSEL in RESP", bus.PSEL, 0);
        @(negedge clk);
        chk("t1 cmd_ready M+1", bus.cmd_ready, 1);
        chk("t1 PADDR held", bus.PADDR, 8'h04);

        // Read 0x08, three wait states, data 0x3C.
        issue(1'b0, 8'h08, 8'h00, 3, 8'h3C, 1'b0, 1'b0);
        run_to_resp(20, n, got, rd, er, to);
        chk("t2 ACCESS cycles", n, 4);
        chk("t2 rsp_rdata", rd, 8'h3C);
        wait_idle();

        // Read with PSLVERR, response held for 5 cycles.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 8'h10, 8'h00, 1, 8'h77, 1'b1, 1'b0);
        run_to_resp(20, n, got, rd, er, to);
        chk("t3 rsp_err", er, 1);
        chk("t3 rsp_timeout", to, 0);
        chk("t3 rsp_rdata", rd, 8'h77);
        for (int i = 0; i < 5; i++) begin
            chk("t3 held rsp_valid", bus.rsp_valid, 1);
            chk("t3 held cmd_ready", bus.cmd_ready, 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3 cmd_ready after consume", bus.cmd_ready, 1);

        // Reset in the middle of ACCESS of a write.
        issue(1'b1, 8'h20, 8'h5A, 5, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4 in ACCESS", bus.PENABLE, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4 PSEL", bus.PSEL, 0);
        chk("t4 PENABLE", bus.PENABLE, 0);
        chk("t4 rsp_valid", bus.rsp_valid, 0);
        chk("t4 cmd_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // PREADY stuck low.
        issue(1'b0, 8'h30, 8'h00, 0, 8'h00, 1'b0, 1'b1);
`ifdef APB_MST_TIMEOUT_EN
        run_to_resp(60, n, got, rd, er, to);
        chk("t5 ACCESS cycles", n, 16);
        chk("t5 rsp_err", er, 1);
        chk("t5 rsp_timeout", to, 1);
        chk("t5 rsp_rdata", rd, 8'h00);
        wait_idle();
`else
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus.PENABLE === 1'b1) n++;
            @(negedge clk);
        end
        chk("t5 stuck ACCESS cycles", n, 120);
        chk("t5 no response", bus.rsp_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        cfg_stuck = 1'b0;
        @(negedge clk);

        // PREADY rises on the 16th ACCESS cycle: normal completion.
        issue(1'b0, 8'h31, 8'h00, 15, 8'h5A, 1'b0, 1'b0);
        run_to_resp(40, n, got, rd, er, to);
        chk("t6 ACCESS cycles", n, 16);
        chk("t6 rsp_rdata", rd, 8'h5A);
        chk("t6 rsp_err", er, 0);
        chk("t6 rsp_timeout", to, 0);
        wait_idle();

        // Back-to-back with cmd_valid held high.
        cfg_wait  = 0;
        cfg_rdata = 8'h66;
        cfg_err   = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start = acc_count;
            bus.cmd_write = i[0];
            bus.cmd_addr  = 8'h40 + 8'(i);
            bus.cmd_wdata = 8'hC0 + 8'(i);
            for (int k = 0; k < 20 && acc_count == start; k++) @(negedge clk);
            chk("t7 accept", acc_count != start, 1);
            tacc[i] = cyc;
        end
        bus.cmd_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("t7 spacing", tacc[i] - tacc[i-1], 4);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
